pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake, stall
//  back-pressure, synchronous flush and an optional 2-entry skid buffer.
//  Replaces fixed-width flush-only stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB);
//  callers pack control/data fields into one payload bus. Flush/reset inject a bubble.
// PARAMETERS
//  DW        32        payload width in bits (>=1)
//  FLUSH_VAL {DW{1'b0}} payload value driven for a bubble (e.g. NOP encoding)
//  SKID      1         1: 2-entry skid, registered in_ready; 0: 1-entry, combinational in_ready
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    asynchronous, active-low reset
//  flush      in   1    synchronous flush: discard all held/incoming beats
//  in_valid   in   1    upstream beat valid
//  in_ready   out  1    stage can accept; beat transfers when in_valid & in_ready
//  in_data    in   DW   upstream payload
//  out_valid  out  1    out_data holds a valid beat
//  out_ready  in   1    downstream accepts; beat leaves when out_valid & out_ready
//  out_data   out  DW   payload from main register
//  occupancy  out  2    beats held: 0,1,2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset (rst=0, async): state EMPTY, main/skid <= FLUSH_VAL, out_valid=0,
//    occupancy=0, in_ready forced 0 while rst=0; in_ready=1 from first edge after release.
//  - in_fire = in_valid&in_ready; out_fire = out_valid&out_ready. Latency in->out: 1 cycle.
//  - out_valid = (state!=EMPTY); out_data = main; occupancy = encoded state.
//  - SKID=1: in_ready = (state!=FULL), from state register only (no comb path from out_ready).
//    EMPTY: in_fire -> ONE, main<=in_data; else stay.
//    ONE:   in_fire&out_fire -> ONE, main<=in_data; in_fire only -> FULL, skid<=in_data;
//           out_fire only -> EMPTY, main<=FLUSH_VAL; neither -> stay.
//    FULL:  out_fire -> ONE, main<=skid, skid<=FLUSH_VAL; else stay (in_ready=0).
//  - SKID=0: no skid register; in_ready = ~out_valid | out_ready (combinational).
//    EMPTY/ONE transitions as above; in_fire in ONE requires out_fire (replace main).
//  - Order preserved: beats leave in acceptance order; no beat duplicated or dropped
//    except by flush.
//  - Flush (highest priority over handshakes): next state EMPTY, main/skid <= FLUSH_VAL.
//    A beat with in_fire in the flush cycle is discarded. A beat with out_fire in the
//    flush cycle counts as delivered. in_ready in the flush cycle follows normal rules.
//  - Payload registers hold while stalled (out_valid & ~out_ready); in_data not sampled
//    without in_fire. Upstream must hold in_data stable while in_valid & ~in_ready.
//  - X-safety: main/skid never capture in_data unless in_fire.
// TESTING
//  1 Reset: rst=0 mid-FULL -> same cycle out_valid=0, occupancy=0, out_data=FLUSH_VAL,
//    in_ready=0; after release in_ready=1.
//  2 Stream: SKID=1, out_ready=1, in_data 1..8 each cycle -> out_data 1..8 one cycle
//    later, occupancy stays 1, in_ready stays 1.
//  3 Stall/skid: send A,B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A; raise
//    out_ready -> A then B delivered, in_ready back to 1 next cycle, occupancy 1 then 0.
//  4 Flush: FULL with A,B, flush=1 with in_valid (C) -> next cycle occupancy=0,
//    out_valid=0, out_data=FLUSH_VAL (e.g. 0x00000013); A,B,C never appear.
//  5 SKID=0, DW=8: out_valid=1, out_ready=0 -> in_ready=0; out_ready=1 with in_valid
//    data 0x5A -> same cycle in_ready=1, next cycle out_data=0x5A.
//  6 Random valid/ready with scoreboard, both SKID values, 10k cycles incl. random
//    flushes -> in-order, no loss/dup outside flush windows.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, stall back-pressure
// and a synchronous flush. An optional second (skid) entry lets in_ready come
// straight from a flop. Callers pack all stage fields into one payload bus.
// Flush and reset both leave a bubble carrying FLUSH_VAL.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | no beat held; out_valid=0, main holds FLUSH_VAL
// ST_ONE   | one beat held in main, presented on out_data
// ST_FULL  | two beats held: oldest in main, newest in skid (SKID=1 only)
module pipe_skid_reg #(
  parameter int unsigned    DW        = 32,
  parameter logic [DW-1:0]  FLUSH_VAL = '0,
  parameter bit             SKID      = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  // The state encoding is the occupancy count, so occupancy needs no decoder.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] main_q;
  logic [DW-1:0] main_d;
  logic [DW-1:0] skid_q;
  logic [DW-1:0] skid_d;
  logic          rdy_en_q;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Holds in_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en_q <= 1'b0;
    else      rdy_en_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  // Main payload register; it is what the downstream stage sees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) main_q <= FLUSH_VAL;
    else      main_q <= main_d;
  end

  // The skid entry only exists in the two-entry configuration.
  generate
    if (SKID) begin : g_skid
      // Skid payload register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) skid_q <= FLUSH_VAL;
        else      skid_q <= skid_d;
      end
    end else begin : g_no_skid
      assign skid_q = FLUSH_VAL;
    end
  endgenerate

  // Next-state and payload selection; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Without a skid entry in_ready already implies out_fire here,
          // so this branch is only reachable with SKID=1.
          if (SKID) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = FLUSH_VAL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = FLUSH_VAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = FLUSH_VAL;
        skid_d  = FLUSH_VAL;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end
  end

  // Outputs. With a skid entry in_ready depends on flops only. Without one it
  // also looks at out_ready, so a full stage can be refilled in the cycle it drains.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_data  = main_q;
    occupancy = state_q;
    if (SKID) in_ready = rdy_en_q & (state_q != ST_FULL);
    else      in_ready = rdy_en_q & (~out_valid | out_ready);
  end

endmodule
